// File: rtl/cla_nibble_seq_if.sv
// Request/result bundle between a requester and the nibble-serial CLA adder.
// The requester drives the operands and start; the adder returns status and result.
interface cla_nibble_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf, zero
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf, zero
  );
endinterface

// File: rtl/cla_nibble_seq.sv
// Wide adder/subtractor that reuses one 4-bit carry-lookahead slice per cycle,
// least-significant nibble first, with a registered carry between nibbles.
module cla_nibble_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NIB   = WIDTH / 4
) (
  input logic              clk,
  input logic              rst_n,
  cla_nibble_seq_if.slave  bus
);

  localparam int unsigned CntW = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] b_eff;
  logic [3:0]       sl_a, sl_b, sl_g, sl_p, sl_s;
  logic [4:0]       sl_c;

  assign b_eff = bus.b ^ {WIDTH{bus.sub}};

  // 4-bit carry-lookahead slice; group PG/GG is not needed by the sequencer.
  assign sl_a    = a_sh_q[3:0];
  assign sl_b    = b_sh_q[3:0];
  assign sl_g    = sl_a & sl_b;
  assign sl_p    = sl_a ^ sl_b;
  assign sl_c[0] = carry_q;
  assign sl_c[1] = sl_g[0] | (sl_p[0] & sl_c[0]);
  assign sl_c[2] = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & sl_c[0]);
  assign sl_c[3] = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
                 | (sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
  assign sl_c[4] = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
                 | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
                 | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
  assign sl_s    = sl_p ^ sl_c[3:0];

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StRun;
          a_sh_d  = bus.a;
          b_sh_d  = b_eff;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
          res_d   = '0;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = b_eff[WIDTH-1];
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        res_d   = {sl_s, res_q[WIDTH-1:4]};
        a_sh_d  = {4'b0000, a_sh_q[WIDTH-1:4]};
        b_sh_d  = {4'b0000, b_sh_q[WIDTH-1:4]};
        carry_d = sl_c[4];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntW'(NIB - 1)) begin
          state_d = StDone;
          sum_d   = res_d;
          cout_d  = sl_c[4];
          ovf_d   = (a_msb_q == b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
          zero_d  = (res_d == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Scoreboard bench for cla_nibble_seq: stimulus queues expected results, a
// negedge monitor pops and compares them whenever done is seen.
module tb_cla_nibble_seq;

  localparam int unsigned WIDTH = 16;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_nibble_seq_if #(.WIDTH(WIDTH)) bus ();

  cla_nibble_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] last_sum = 16'h0000;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sum",  bus.sum,  e.sum);
        check("cout", bus.cout, e.cout);
        check("ovf",  bus.ovf,  e.ovf);
        check("zero", bus.zero, e.zero);
      end
    end
  end

  task automatic run_op(input logic s, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input exp_t e, input bit poke);
    @(negedge clk);
    bus.start = 1'b1; bus.sub = s; bus.a = a; bus.b = b; bus.cin = c;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0; bus.a = 16'hDEAD; bus.b = 16'hBEEF; bus.cin = 1'b1;
    check("busy_run0", bus.busy, 1);
    check("sum_hold", bus.sum, last_sum);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (poke && i == 0) begin
        bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h1111;
      end else begin
        bus.start = 1'b0;
      end
      check("busy_run", bus.busy, 1);
      check("done_early", bus.done, 0);
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("done_pulse", bus.done, 1);
    check("busy_at_done", bus.busy, 0);
    last_sum = e.sum;
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    check("busy_idle", bus.busy, 0);
    if (poke) begin
      repeat (5) begin
        @(negedge clk);
        check("no_second_op", bus.busy | bus.done, 0);
      end
    end
  endtask

  initial begin
    int t1;
    int t2;
    int dones;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_sum",  bus.sum,  0);
    check("rst_cout", bus.cout, 0);
    check("rst_ovf",  bus.ovf,  0);
    check("rst_zero", bus.zero, 1);
    rst_n = 1'b1;

    run_op(1'b0, 16'h1234, 16'h4321, 1'b0, '{16'h5555, 1'b0, 1'b0, 1'b0}, 1'b0);
    run_op(1'b0, 16'hFFFF, 16'h0000, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1}, 1'b0);
    run_op(1'b1, 16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1, 1'b0}, 1'b0);
    run_op(1'b1, 16'h0003, 16'h0005, 1'b0, '{16'hFFFE, 1'b0, 1'b0, 1'b0}, 1'b0);
    run_op(1'b0, 16'h0001, 16'h0001, 1'b0, '{16'h0002, 1'b0, 1'b0, 1'b0}, 1'b1);

    // Back-to-back: start held across the first DONE cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.sub = 1'b0; bus.a = 16'h00FF; bus.b = 16'h0001; bus.cin = 1'b0;
    exp_q.push_back('{16'h0100, 1'b0, 1'b0, 1'b0});
    exp_q.push_back('{16'h8000, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    bus.a = 16'h7000; bus.b = 16'h1000;
    t1 = -1; t2 = -1; dones = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        if (t1 < 0) t1 = k;
        else t2 = k;
      end
      if (t1 > 0 && k == t1 + 1) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    check("b2b_done_count", dones, 2);
    check("b2b_first_at", t1, 4);
    check("b2b_spacing", t2 - t1, 5);
    last_sum = 16'h8000;

    // Reset during the 2nd RUN cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h0005; bus.b = 16'h0003; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_sum",  bus.sum,  0);
    check("mid_rst_zero", bus.zero, 1);
    rst_n = 1'b1;
    last_sum = 16'h0000;
    repeat (6) begin
      @(negedge clk);
      check("no_done_after_rst", bus.done, 0);
    end
    run_op(1'b0, 16'h0005, 16'h0003, 1'b0, '{16'h0008, 1'b0, 1'b0, 1'b0}, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
